ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

- Sequences the `ps2_keyboard` receiver: acknowledges each scan code through the `nextdata_n` handshake and buffers codes in a local FIFO.
- Exposes the FIFO, a status word and a control word to the CPU through an APB3 slave with zero wait states.
- Sits between the keyboard receiver and the APB interconnect and replaces the tied-off `nextdata_n` arrangement.
- Raises a level interrupt while codes are pending.

## Interface
- `FIFO_DEPTH`, 8 — scan-code FIFO entries; power of two, 2..64
- `clk`  in  1  — single clock; all logic is on the rising edge
- `rst_n`  in  1  — asynchronous active-low reset
- `kbd_ready`  in  1  — receiver has an unread code
- `kbd_scan_code`  in  8  — receiver head code, valid while `kbd_ready`=1
- `kbd_overflow`  in  1  — receiver internal buffer overflowed
- `kbd_nextdata_n`  out  1  — active-low acknowledge to receiver, one-cycle pulse
- `paddr`  in  32  — APB address; only [3:0] decoded
- `psel`, `penable`, `pwrite`  in  1 each  — APB control
- `pwdata`  in  32  — APB write data
- `pstrb`  in  4  — byte strobes; only bit 0 is honoured
- `pready`  out  1  — constant 1
- `prdata`  out  32  — APB read data
- `pslverr`  out  1  — APB error
- `irq`  out  1  — interrupt, level

## Operation
- **Register map** (offset = `paddr[3:0]`):
  - 0x0 DATA, read-only.
    - Returns `{24'b0, head}` and pops the FIFO.
    - When empty, returns 0 and does not pop.
  - 0x4 STATUS, read-only.
    - bit0 = not_empty, bit1 = full, bit2 = ovf (sticky).
    - bits[8+CW-1:8] = count, where CW = log2(FIFO_DEPTH)+1.
    - All other bits 0.
  - 0x8 CTRL, read/write.
    - bit0 = irq_en.
    - bit1: write-1-to-clear ovf; this bit reads as 0.
    - A write applies only when `pstrb[0]`=1.
- **pslverr**: asserted in the access phase for:
  - offsets 0xC..0xF or `paddr[1:0]`≠0;
  - writes to DATA or STATUS.
  - An errored access has no side effects and returns `prdata`=0.
- **Fetch FSM**, three states:
  - IDLE: if `kbd_ready` and FIFO not full → go to ACK; otherwise stay.
  - ACK:
    - Drive `kbd_nextdata_n`=0.
    - Push `kbd_scan_code`, sampled in this cycle, into the FIFO.
    - Go to SETTLE.
  - SETTLE: ignore `kbd_ready` for one cycle while the receiver advances its pointer, then go to IDLE.
- **FIFO full**: the FSM holds in IDLE and `kbd_nextdata_n` stays 1. Backpressure is left to the receiver's own buffer.
- **ovf**:
  - Set on any cycle with `kbd_overflow`=1.
  - Cleared by a CTRL write with bit1=1.
  - Set wins over clear in the same cycle.
- **irq**: `irq` = irq_en & not_empty, driven from registered state with no combinational path from APB inputs.
- **Pointers**: log2(FIFO_DEPTH)-bit, wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- **Push and pop in the same cycle**:
  - If the FIFO is not empty, both occur and count is unchanged.
  - If the FIFO is empty, the pop is ignored (DATA returns 0) and the push proceeds.

## Timing
- **Reset values**:
  - FSM = IDLE, FIFO empty, count=0, ovf=0, irq_en=0.
  - `kbd_nextdata_n`=1, `irq`=0, `pslverr`=0, `prdata`=0.
  - `pready`=1 at all times.
- **APB** (zero wait states):
  - Setup phase is `psel`=1, `penable`=0; no side effects.
  - Access phase is `psel`=1, `penable`=1; it completes in that cycle.
  - `prdata` and `pslverr` are combinational from the registered state and are valid in the access phase.
  - Outside a read access phase, `prdata`=0.
- **Pop**: the read pointer advances at the end of the DATA access cycle.
- **Fetch latency**:
  - `kbd_ready` seen in IDLE at cycle T → ACK at T+1 (nextdata_n low in T+1 only).
  - The code is readable from cycle T+2.
  - SETTLE is at T+2; the next code can be accepted no earlier than ACK at T+4.
- **Throughput**: peak is one code per 3 cycles.
- **Reset mid-operation**: `rst_n` low asynchronously forces the reset values.
  - A pulse in progress on `kbd_nextdata_n` is cut short.
  - Any code not yet pushed stays in the receiver.

## Test plan
- Present code 0x1C with `kbd_ready`=1 → `kbd_nextdata_n` low exactly one cycle; STATUS reads 0x00000101; DATA reads 0x1C; STATUS then reads 0.
- Read DATA while empty → `prdata`=0, `pslverr`=0, count stays 0.
- Push 9 codes 0x01..0x09 with FIFO_DEPTH=8 → STATUS reads 0x00000803; no ACK for 0x09 until one DATA read; then 0x09 is accepted and the FIFO returns 0x01..0x09 in order.
- Enable irq (CTRL=1), push 0x5A → `irq`=1 two cycles after `kbd_ready`; one DATA read → `irq`=0 the next cycle.
- Pulse `kbd_overflow` → STATUS bit2=1.
  - CTRL write 0x2 → bit2=0.
  - Overflow pulse in the same cycle as a clear write → bit2 stays 1.
- Write DATA, read offset 0xC, access 0x2 → `pslverr`=1, no pop, state unchanged.
- Assert `rst_n` low during ACK → `kbd_nextdata_n`=1 and the FIFO is empty immediately.

Source files
------------

// File: rtl/ps2_rx_ctrl_if.sv
// APB3 slave bundle for the PS/2 receive controller.
// The master modport is the interconnect (or bench) side, the slave modport
// is the controller side.
interface ps2_rx_ctrl_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller.
// Pulls scan codes out of the ps2_keyboard receiver with a one-cycle
// active-low acknowledge, buffers them in a small FIFO and exposes the FIFO,
// a status word and a control word through a zero-wait-state APB3 slave.
// A level interrupt is raised while codes are pending and irq_en is set.
module ps2_rx_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kbd_ready,
  input  logic [7:0]   kbd_scan_code,
  input  logic         kbd_overflow,
  output logic         kbd_nextdata_n,
  ps2_rx_ctrl_if.slave apb,
  output logic         irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_SETTLE
  } fetch_state_t;

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [7:0]    head;

  logic          ovf;
  logic          irq_en;

  logic          fifo_push;
  logic          fifo_pop;

  logic [3:0]    offset;
  logic          access;
  logic          addr_bad;
  logic          write_ro;
  logic          acc_err;
  logic          rd_ok;
  logic          ctrl_we;
  logic [31:0]   status_word;

  logic          unused_apb;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = mem[rd_ptr];

  // APB decode: only offset bits are looked at; an access is valid only on
  // a word-aligned register that allows the requested direction.
  assign offset   = apb.paddr[3:0];
  assign access   = apb.psel & apb.penable;
  assign addr_bad = (offset[3:2] == 2'b11) | (offset[1:0] != 2'b00);
  assign write_ro = apb.pwrite & ((offset == OFF_DATA) | (offset == OFF_STATUS));
  assign acc_err  = addr_bad | write_ro;
  assign rd_ok    = access & ~apb.pwrite & ~acc_err;
  assign ctrl_we  = access & apb.pwrite & ~acc_err & (offset == OFF_CTRL) & apb.pstrb[0];
  assign fifo_pop = rd_ok & (offset == OFF_DATA) & ~empty;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & acc_err;

  // Interrupt depends only on registered state, never on the APB inputs.
  assign irq = irq_en & ~empty;

  // Bits of the bus that carry no meaning for this block.
  assign unused_apb = ^{apb.paddr[31:4], apb.pwdata[31:2], apb.pstrb[3:1]};

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state and handshake: ACK pulses nextdata_n and pushes the
  // head code; SETTLE blinds the FSM while the receiver moves to its next code.
  always_comb begin
    state_d        = state_q;
    kbd_nextdata_n = 1'b1;
    fifo_push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kbd_ready && !full) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        kbd_nextdata_n = 1'b0;
        fifo_push      = 1'b1;
        state_d        = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr] <= kbd_scan_code;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control register and sticky overflow flag; a new overflow beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (ctrl_we) begin
        irq_en <= apb.pwdata[0];
      end
      if (kbd_overflow) begin
        ovf <= 1'b1;
      end else if (ctrl_we && apb.pwdata[1]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Status word layout: not_empty, full, ovf, then the occupancy count at bit 8.
  always_comb begin
    status_word            = 32'h0;
    status_word[0]         = ~empty;
    status_word[1]         = full;
    status_word[2]         = ovf;
    status_word[8 +: CW]   = count;
  end

  // Read mux; zero outside a valid read access and for DATA while empty.
  always_comb begin
    apb.prdata = 32'h0;
    if (rd_ok) begin
      case (offset)
        OFF_DATA: begin
          if (!empty) begin
            apb.prdata = {24'h0, head};
          end
        end
        OFF_STATUS: begin
          apb.prdata = status_word;
        end
        OFF_CTRL: begin
          apb.prdata = {31'h0, irq_en};
        end
        default: begin
          apb.prdata = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: emulates the keyboard receiver as a queue of codes,
// drives APB transfers and compares against a queue-based reference model.
module tb_ps2_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kbd_ready;
  logic [7:0] kbd_scan_code;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       irq;

  ps2_rx_ctrl_if bus ();

  ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kbd_ready      (kbd_ready),
    .kbd_scan_code  (kbd_scan_code),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .apb            (bus),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  logic [7:0]  model_q [$];
  logic [7:0]  rx_q [$];
  logic        irq_en_m;
  logic        ovf_m;
  int          total;
  int          bad;
  int          cyc;
  int          ack_count;
  int          last_ack_cyc;
  logic        chk_bg;
  logic [31:0] obs_prdata;
  logic        obs_err;
  logic        obs_irq;
  logic        obs_nd;
  logic [31:0] exp_prdata;
  logic        exp_err;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (model_q.size() != 0);
    s[1]    = (model_q.size() == DEPTH);
    s[2]    = ovf_m;
    s[15:8] = 8'(model_q.size());
    return s;
  endfunction

  task automatic drive_rx();
    kbd_ready     = (rx_q.size() != 0);
    kbd_scan_code = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic give_code(input logic [7:0] code);
    rx_q.push_back(code);
    drive_rx();
  endtask

  // One clock: sample outputs just before the edge, check, then update the
  // receiver emulation and the reference model after the edge.
  task automatic applyStimulus();
    logic       acc;
    logic       err_e;
    logic       rd;
    logic       ack;
    logic       ovf_in;
    logic       do_pop;
    logic       do_ctrl;
    logic [3:0] off;
    #3;
    cyc++;
    off     = bus.paddr[3:0];
    acc     = bus.psel && bus.penable;
    err_e   = (off >= 4'hC) || (off[1:0] != 2'b00) ||
              (bus.pwrite && ((off == 4'h0) || (off == 4'h4)));
    rd      = acc && !bus.pwrite && !err_e;
    do_pop  = 1'b0;
    exp_prdata = 32'h0;
    if (rd) begin
      if (off == 4'h0) begin
        if (model_q.size() != 0) begin
          exp_prdata = {24'h0, model_q[0]};
          do_pop     = 1'b1;
        end
      end else if (off == 4'h4) begin
        exp_prdata = model_status();
      end else begin
        exp_prdata = {31'h0, irq_en_m};
      end
    end
    exp_err = acc && err_e;
    do_ctrl = acc && bus.pwrite && !err_e && (off == 4'h8) && bus.pstrb[0];
    ack     = (kbd_nextdata_n === 1'b0);
    ovf_in  = kbd_overflow;
    obs_prdata = bus.prdata;
    obs_err    = bus.pslverr;
    obs_irq    = irq;
    obs_nd     = kbd_nextdata_n;
    if (acc) begin
      checkOutput("prdata", obs_prdata, exp_prdata);
      checkOutput("pslverr", 32'(obs_err), 32'(exp_err));
    end
    if (chk_bg) begin
      checkOutput("irq", 32'(obs_irq), 32'(irq_en_m && (model_q.size() != 0)));
      checkOutput("pready", 32'(bus.pready), 32'h1);
      if (!acc) checkOutput("prdata_idle", obs_prdata, 32'h0);
    end
    if (ack) begin
      checkOutput("ack_room", 32'(model_q.size() < DEPTH), 32'h1);
      checkOutput("ack_gap", 32'((cyc - last_ack_cyc) >= 3), 32'h1);
      checkOutput("ack_ready", 32'(rx_q.size() != 0), 32'h1);
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(model_q.pop_front());
    if (ack && (rx_q.size() != 0)) begin
      model_q.push_back(rx_q.pop_front());
      ack_count++;
      last_ack_cyc = cyc;
    end
    if (do_ctrl) begin
      irq_en_m = bus.pwdata[0];
      if (bus.pwdata[1]) ovf_m = 1'b0;
    end
    if (ovf_in) ovf_m = 1'b1;
    kbd_overflow = 1'b0;
    drive_rx();
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = addr;
    bus.pstrb   = 4'hF;
    applyStimulus();
    bus.penable = 1'b1;
    applyStimulus();
    data = obs_prdata;
    err  = obs_err;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = 32'h0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic ovf_pulse);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pstrb   = strb;
    applyStimulus();
    bus.penable  = 1'b1;
    kbd_overflow = ovf_pulse;
    applyStimulus();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 32'h0;
    bus.pwdata  = 32'h0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          acks0;
    total = 0; bad = 0; cyc = 0; ack_count = 0; last_ack_cyc = -10;
    irq_en_m = 1'b0; ovf_m = 1'b0; chk_bg = 1'b0;
    kbd_ready = 1'b0; kbd_scan_code = 8'h00; kbd_overflow = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pwdata = 32'h0; bus.pstrb = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    checkOutput("rst_nextdata_n", 32'(kbd_nextdata_n), 32'h1);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_pslverr", 32'(bus.pslverr), 32'h0);
    checkOutput("rst_prdata", bus.prdata, 32'h0);
    checkOutput("rst_pready", 32'(bus.pready), 32'h1);
    apb_read(32'h4, d, e);
    checkOutput("rst_status", d, 32'h0);

    $display("[TB] single code fetch");
    acks0 = ack_count;
    give_code(8'h1C);
    applyStimulus();
    checkOutput("nd_at_T", 32'(obs_nd), 32'h1);
    applyStimulus();
    checkOutput("nd_at_T1", 32'(obs_nd), 32'h0);
    applyStimulus();
    checkOutput("nd_at_T2", 32'(obs_nd), 32'h1);
    repeat (3) applyStimulus();
    checkOutput("ack_once", 32'(ack_count - acks0), 32'h1);
    apb_read(32'h4, d, e);
    checkOutput("status_one", d, 32'h0000_0101);
    apb_read(32'h0, d, e);
    checkOutput("data_1c", d, 32'h0000_001C);
    apb_read(32'h4, d, e);
    checkOutput("status_after_pop", d, 32'h0);

    $display("[TB] empty read");
    apb_read(32'h0, d, e);
    checkOutput("empty_data", d, 32'h0);
    checkOutput("empty_err", 32'(e), 32'h0);
    apb_read(32'h4, d, e);
    checkOutput("empty_status", d, 32'h0);

    $display("[TB] fill past depth");
    for (int i = 1; i <= 9; i++) give_code(8'(i));
    repeat (40) applyStimulus();
    apb_read(32'h4, d, e);
    checkOutput("status_full", d, 32'h0000_0803);
    checkOutput("rx_held", 32'(rx_q.size()), 32'h1);
    apb_read(32'h0, d, e);
    checkOutput("full_data_1", d, 32'h1);
    repeat (6) applyStimulus();
    checkOutput("rx_drained", 32'(rx_q.size()), 32'h0);
    for (int i = 2; i <= 9; i++) begin
      apb_read(32'h0, d, e);
      checkOutput("full_order", d, 32'(i));
    end

    $display("[TB] interrupt");
    apb_write(32'h8, 32'h1, 4'hF, 1'b0);
    apb_read(32'h8, d, e);
    checkOutput("ctrl_irq_en", d, 32'h1);
    give_code(8'h5A);
    applyStimulus();
    checkOutput("irq_T", 32'(obs_irq), 32'h0);
    applyStimulus();
    checkOutput("irq_T1", 32'(obs_irq), 32'h0);
    applyStimulus();
    checkOutput("irq_T2", 32'(obs_irq), 32'h1);
    apb_read(32'h0, d, e);
    checkOutput("irq_data", d, 32'h5A);
    applyStimulus();
    checkOutput("irq_cleared", 32'(obs_irq), 32'h0);

    $display("[TB] overflow flag");
    kbd_overflow = 1'b1;
    applyStimulus();
    apb_read(32'h4, d, e);
    checkOutput("ovf_set", d, 32'h4);
    apb_write(32'h8, 32'h2, 4'hF, 1'b0);
    apb_read(32'h4, d, e);
    checkOutput("ovf_cleared", d, 32'h0);
    apb_write(32'h8, 32'h2, 4'hF, 1'b1);
    apb_read(32'h4, d, e);
    checkOutput("ovf_set_wins", d, 32'h4);

    $display("[TB] error accesses");
    give_code(8'hA5);
    repeat (4) applyStimulus();
    apb_write(32'h0, 32'hFF, 4'hF, 1'b0);
    checkOutput("err_wr_data", 32'(obs_err), 32'h1);
    apb_write(32'h4, 32'hFF, 4'hF, 1'b0);
    checkOutput("err_wr_status", 32'(obs_err), 32'h1);
    apb_read(32'hC, d, e);
    checkOutput("err_rd_c", 32'(e), 32'h1);
    checkOutput("err_rd_c_data", d, 32'h0);
    apb_read(32'h2, d, e);
    checkOutput("err_rd_2", 32'(e), 32'h1);
    apb_write(32'h8, 32'h1, 4'hE, 1'b0);
    apb_read(32'h8, d, e);
    checkOutput("ctrl_no_strb", d, 32'h0);
    apb_read(32'h4, d, e);
    checkOutput("err_status_kept", d, 32'h0000_0105);
    apb_read(32'h0, d, e);
    checkOutput("err_data_kept", d, 32'hA5);

    $display("[TB] random traffic");
    chk_bg = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          if (rx_q.size() < 4) give_code(8'($urandom));
          applyStimulus();
        end
        3, 4, 5: apb_read(32'h0, d, e);
        6:       apb_read(32'h4, d, e);
        7: begin
          kbd_overflow = 1'b1;
          applyStimulus();
        end
        8:       apb_write(32'h8, {30'h0, 2'($urandom)}, 4'($urandom), 1'($urandom));
        default: apb_read(32'($urandom_range(0, 15)), d, e);
      endcase
    end
    repeat (30) applyStimulus();
    for (int n = 0; n < DEPTH + 1; n++) apb_read(32'h0, d, e);
    apb_read(32'h4, d, e);
    checkOutput("rand_end_count", 32'(d[15:8]), 32'h0);
    chk_bg = 1'b0;

    $display("[TB] reset during ACK");
    apb_write(32'h8, 32'h1, 4'hF, 1'b0);
    give_code(8'h11);
    repeat (5) applyStimulus();
    checkOutput("pre_rst_irq", 32'(irq), 32'h1);
    give_code(8'h22);
    applyStimulus();
    checkOutput("in_ack", 32'(kbd_nextdata_n), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ack_nd", 32'(kbd_nextdata_n), 32'h1);
    checkOutput("rst_ack_irq", 32'(irq), 32'h0);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h4;
    #1;
    checkOutput("rst_ack_status", bus.prdata, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_q.delete();
    irq_en_m = 1'b0;
    ovf_m = 1'b0;
    last_ack_cyc = -10;
    repeat (5) applyStimulus();
    apb_read(32'h0, d, e);
    checkOutput("post_rst_code", d, 32'h22);
    apb_read(32'h4, d, e);
    checkOutput("post_rst_status", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
